// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and width helpers for the spi_master_mc slice.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    // cs_sel keeps at least one bit even for a single chip select
    function automatic int cs_width(input int cs_num);
        return (cs_num > 1) ? $clog2(cs_num) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clkgen
// Description : Half-period counter producing SCLK and leading/trailing strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clkgen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 toggle_en,
    input  logic                 cpol,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 sclk,
    output logic                 tick,
    output logic                 lead_stb,
    output logic                 trail_stb
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_sclk;
    logic                 w_tick;

    assign w_tick = run && (r_cnt == clk_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!run) begin
            r_cnt  <= '0;
            r_sclk <= cpol;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
            if (w_tick && toggle_en) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

    // Strobes flag the clk edge that will move SCLK away from / back to idle
    assign sclk      = r_sclk;
    assign tick      = w_tick;
    assign lead_stb  = w_tick && toggle_en && (r_sclk == cpol);
    assign trail_stb = w_tick && toggle_en && (r_sclk != cpol);

endmodule
`default_nettype wire

// File: rtl/spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_mc
// Description : Multi-CS, mode-selectable SPI master; SPI_LOOPBACK_EN adds an
//               internal MOSI->receive loopback input.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CS_NUM     = 1,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic [cs_width(CS_NUM)-1:0] cs_sel,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        lsb_first,
    input  logic [DIV_WIDTH-1:0]        clk_div,
    output logic                        busy,
    output logic                        finish,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        sclk,
    output logic                        mosi,
    input  logic                        miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                        loopback,
`endif
    output logic [CS_NUM-1:0]           cs_n
);

    localparam int                c_cs_w    = cs_width(CS_NUM);
    localparam logic [c_cs_w:0]   c_cs_num  = (c_cs_w + 1)'(CS_NUM);
    localparam int                c_hp_w    = $clog2(2 * DATA_WIDTH);
    localparam logic [c_hp_w-1:0] c_hp_last = c_hp_w'(2 * DATA_WIDTH - 1);

    spi_state_t            r_state;
    spi_state_t            w_state_nxt;
    spi_mode_t             r_mode;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [c_cs_w-1:0]     r_cs_sel;
    logic [c_cs_w-1:0]     w_cs_sel_nxt;
    logic [CS_NUM-1:0]     r_cs_n;
    logic [CS_NUM-1:0]     w_cs_n_nxt;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_mosi;
    logic [c_hp_w-1:0]     r_hp;

    logic w_accept;
    logic w_run;
    logic w_toggle_en;
    logic w_cpol_gen;
    logic w_tick;
    logic w_lead_stb;
    logic w_trail_stb;
    logic w_drive;
    logic w_sample;
    logic w_rx_bit;

    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] word, input logic lsb);
        return lsb ? word[0] : word[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] word,
                                                       input logic lsb);
        return lsb ? (word >> 1) : (word << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] put_bit(input logic [DATA_WIDTH-1:0] word,
                                                      input logic bit_in, input logic lsb);
        return lsb ? {bit_in, word[DATA_WIDTH-1:1]} : {word[DATA_WIDTH-2:0], bit_in};
    endfunction

    assign w_accept    = (r_state == IDLE) && start && ({1'b0, cs_sel} < c_cs_num);
    assign w_run       = (r_state == LEAD) || (r_state == SHIFT) || (r_state == TRAIL);
    // SCLK toggles entering every SHIFT half-period; the last one stays at idle level
    assign w_toggle_en = (r_state == LEAD) || ((r_state == SHIFT) && (r_hp != c_hp_last));
    assign w_cpol_gen  = w_accept ? cpol : r_mode.cpol;
    assign w_drive     = r_mode.cpha ? w_lead_stb  : w_trail_stb;
    assign w_sample    = r_mode.cpha ? w_trail_stb : w_lead_stb;

`ifdef SPI_LOOPBACK_EN
    assign w_rx_bit = loopback ? r_mosi : miso;
`else
    assign w_rx_bit = miso;
`endif

    spi_clkgen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .run       (w_run),
        .toggle_en (w_toggle_en),
        .cpol      (w_cpol_gen),
        .clk_div   (r_div),
        .sclk      (sclk),
        .tick      (w_tick),
        .lead_stb  (w_lead_stb),
        .trail_stb (w_trail_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = LEAD;
            LEAD:    if (w_tick) w_state_nxt = SHIFT;
            SHIFT:   if (w_tick && (r_hp == c_hp_last)) w_state_nxt = TRAIL;
            TRAIL:   if (w_tick) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cs_sel_nxt = w_accept ? cs_sel : r_cs_sel;
        w_cs_n_nxt   = '1;
        if ((w_state_nxt == LEAD) || (w_state_nxt == SHIFT) || (w_state_nxt == TRAIL)) begin
            for (int i = 0; i < CS_NUM; i++) begin
                if (w_cs_sel_nxt == c_cs_w'(i)) begin
                    w_cs_n_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= '0;
            r_div      <= '0;
            r_cs_sel   <= '0;
            r_cs_n     <= '1;
            r_tx       <= '0;
            r_rx       <= '0;
            r_mosi     <= 1'b0;
            r_data_out <= '0;
            r_hp       <= '0;
        end else begin
            r_cs_n <= w_cs_n_nxt;
            if (w_accept) begin
                r_mode.cpol      <= cpol;
                r_mode.cpha      <= cpha;
                r_mode.lsb_first <= lsb_first;
                r_div            <= clk_div;
                r_cs_sel         <= cs_sel;
                r_rx             <= '0;
                r_hp             <= '0;
                // cpha=0 presents the first bit before the first SCLK edge
                if (cpha) begin
                    r_tx <= data_in;
                end else begin
                    r_mosi <= pick_bit(data_in, lsb_first);
                    r_tx   <= drop_bit(data_in, lsb_first);
                end
            end
            if ((r_state == SHIFT) && w_tick) begin
                r_hp <= r_hp + c_hp_w'(1);
            end
            if (w_drive) begin
                r_mosi <= pick_bit(r_tx, r_mode.lsb_first);
                r_tx   <= drop_bit(r_tx, r_mode.lsb_first);
            end
            if (w_sample) begin
                r_rx <= put_bit(r_rx, w_rx_bit, r_mode.lsb_first);
            end
            if ((r_state == TRAIL) && w_tick) begin
                r_data_out <= r_rx;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign finish   = (r_state == DONE);
    assign data_out = r_data_out;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_mc
// Description : Scoreboard bench for spi_master_mc with a behavioural SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_mc;

    localparam int DW   = 8;
    localparam int CSN  = 3;
    localparam int DIVW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic [1:0]      cs_sel = '0;
    logic            cpol = 1'b0;
    logic            cpha = 1'b0;
    logic            lsb_first = 1'b0;
    logic [DIVW-1:0] clk_div = '0;
    logic            busy;
    logic            finish;
    logic [DW-1:0]   data_out;
    logic            sclk;
    logic            mosi;
    logic            miso;
    logic [CSN-1:0]  cs_n;
    logic            tb_loop = 1'b0;
    logic [DW-1:0]   slave_tx = '0;

    always #5 clk = ~clk;

    spi_master_mc #(
        .DATA_WIDTH (DW),
        .CS_NUM     (CSN),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .clk_div   (clk_div),
        .busy      (busy),
        .finish    (finish),
        .data_out  (data_out),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback  (tb_loop),
`endif
        .cs_n      (cs_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            fin_cyc;
        logic [DW-1:0] slv;
        logic          pol;
    } exp_t;

    exp_t sb_q[$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    // monitor / slave state
    int            acc_cyc = 0;
    int            lat = 0;
    int            bad_win = 0;
    int            fin_count = 0;
    int            last_fin_cyc = 0;
    int            b2b_acc = 0;
    logic          b2b_mode = 1'b0;
    logic          active = 1'b0;
    int            m_sel = 0;
    logic          m_cpol = 1'b0;
    logic          m_cpha = 1'b0;
    logic          m_lsb = 1'b0;
    logic          s_prev_cs = 1'b1;
    logic          s_prev_sclk = 1'b0;
    logic [DW-1:0] s_tx = '0;
    logic [DW-1:0] s_rx = '0;
    logic          s_miso = 1'b0;
    logic          s_first = 1'b0;
    int            s_cnt = 0;

`ifdef SPI_LOOPBACK_EN
    assign miso = s_miso;
`else
    assign miso = tb_loop ? mosi : s_miso;
`endif

    always @(negedge clk) begin
        logic [CSN-1:0] oh;
        logic           cs_low;
        logic           lead;
        exp_t           e;
        if (rst) begin
            sb_q.delete();
            active      = 1'b0;
            s_prev_cs   = 1'b1;
            s_prev_sclk = sclk;
        end else begin
            if (active) begin
                oh = CSN'(1) << m_sel;
                if ((cyc - acc_cyc >= 1) && (cyc - acc_cyc < lat)) begin
                    if ((cs_n !== ~oh) || (busy !== 1'b1)) bad_win++;
                end
            end
            if (finish) begin
                fin_count++;
                last_fin_cyc = cyc;
                active = 1'b0;
                if (sb_q.size() == 0) begin
                    check_val("unexpected_finish", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("data_out", data_out, e.data);
                    check_val("finish_cycle", cyc, e.fin_cyc);
                    check_val("slave_rx", s_rx, e.slv);
                    check_val("cs_busy_window", bad_win, 0);
                    check_val("cs_n_done", cs_n, {CSN{1'b1}});
                    check_val("sclk_done", sclk, e.pol);
                end
            end
            // behavioural slave on chip select m_sel
            cs_low = (cs_n[m_sel] == 1'b0);
            if (cs_low && s_prev_cs) begin
                s_tx  = slave_tx;
                s_rx  = '0;
                s_cnt = 0;
                if (!m_cpha) begin
                    s_miso = m_lsb ? s_tx[0] : s_tx[DW-1];
                    s_tx   = m_lsb ? (s_tx >> 1) : (s_tx << 1);
                end
            end else if (cs_low && (sclk != s_prev_sclk)) begin
                lead = (sclk != m_cpol);
                if (lead != m_cpha) begin
                    if (s_cnt == 0) s_first = mosi;
                    s_rx = m_lsb ? {mosi, s_rx[DW-1:1]} : {s_rx[DW-2:0], mosi};
                    s_cnt++;
                end else begin
                    s_miso = m_lsb ? s_tx[0] : s_tx[DW-1];
                    s_tx   = m_lsb ? (s_tx >> 1) : (s_tx << 1);
                end
            end
            s_prev_cs   = !cs_low;
            s_prev_sclk = sclk;
            // accepted start: push the expected result
            if (start && !busy && (cs_sel < CSN)) begin
                if (b2b_mode) begin
                    if (b2b_acc > 0) check_val("b2b_gap", cyc - last_fin_cyc, 1);
                    b2b_acc++;
                end
                lat     = 1 + (2 * DW + 2) * (int'(clk_div) + 1);
                acc_cyc = cyc;
                active  = 1'b1;
                bad_win = 0;
                m_sel   = int'(cs_sel);
                m_cpol  = cpol;
                m_cpha  = cpha;
                m_lsb   = lsb_first;
                e.data    = tb_loop ? data_in : slave_tx;
                e.fin_cyc = cyc + lat;
                e.slv     = data_in;
                e.pol     = cpol;
                sb_q.push_back(e);
            end
        end
    end

    task automatic do_xfer(input logic [DW-1:0] d, input logic [1:0] sel, input logic pol,
                           input logic pha, input logic lsb, input logic [DIVW-1:0] div,
                           input logic lp, input logic [DW-1:0] stx);
        data_in   = d;
        cs_sel    = sel;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        clk_div   = div;
        tb_loop   = lp;
        slave_tx  = stx;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_finish(input int target, input int budget);
        int k = 0;
        while ((fin_count < target) && (k < budget)) begin
            @(posedge clk); #1;
            k++;
        end
        if (fin_count < target) check_val("finish_timeout", fin_count, target);
    endtask

    initial begin
        int f0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sclk", sclk, 0);
        check_val("rst_mosi", mosi, 0);
        check_val("rst_cs_n", cs_n, 3'b111);
        check_val("rst_busy", busy, 0);
        check_val("rst_finish", finish, 0);
        check_val("rst_data_out", data_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // mode 0, msb first, loopback
        do_xfer(8'hB4, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h3C);
        wait_finish(1, 60);

        // mode 3 against slave returning 0x55
        do_xfer(8'hB4, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 8'h55);
        wait_finish(2, 100);
        check_val("sclk_idle_high", sclk, 1);

        // lsb first, mode 1, loopback, then resend received word
        do_xfer(8'h01, 2'd1, 1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 8'hA5);
        wait_finish(3, 60);
        check_val("lsb_first_bit", s_first, 1);
        do_xfer(data_out, 2'd1, 1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 8'hA5);
        wait_finish(4, 60);
        check_val("lsb_resend_first_bit", s_first, 1);

        // lsb first, mode 2, external slave
        do_xfer(8'h2D, 2'd0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 8'hC6);
        wait_finish(5, 150);

        // cs_sel=2; inputs changed during busy must not matter
        do_xfer(8'h96, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h69);
        repeat (2) @(posedge clk);
        #1;
        cs_sel = 2'd0; data_in = 8'hFF; cpol = 1'b1; lsb_first = 1'b1; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        wait_finish(6, 60);

        // out-of-range chip select is ignored
        f0 = fin_count;
        cs_sel = 2'd3; start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("oor_busy", busy, 0);
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check_val("oor_no_finish", fin_count, f0);

        // reset at cycle 8 of a transfer
        do_xfer(8'h5A, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'h11);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_cs_n", cs_n, 3'b111);
        check_val("abort_busy", busy, 0);
        check_val("abort_sclk", sclk, 0);
        check_val("abort_mosi", mosi, 0);
        f0 = fin_count;
        repeat (30) @(posedge clk);
        #1;
        check_val("abort_no_finish", fin_count, f0);
        do_xfer(8'hE7, 2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 8'h81);
        wait_finish(f0 + 1, 100);

        // start held high: back-to-back transfers
        b2b_mode = 1'b1;
        data_in = 8'hC3; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        clk_div = 8'd0; tb_loop = 1'b1; slave_tx = 8'h0F; start = 1'b1;
        wait_finish(f0 + 4, 120);
        start = 1'b0;
        check_val("b2b_count", b2b_acc, 3);
        repeat (5) @(posedge clk);
        #1;
        check_val("b2b_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
